// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings and MEM-stage LSU state type.
// Imported by the load/store unit and its alignment helper.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / replicated write data,
// alignment check, and load byte/half extraction with sign/zero extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic        aligned,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] lane;

    assign lane = rdata >> {addr_lo, 3'b000};

    always_comb begin
        aligned = 1'b1;
        be      = 4'b1111;
        wdata   = store_data;
        case (funct3)
            F3_B, F3_BU: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            F3_H, F3_HU: begin
                aligned = ~addr_lo[0];
                be      = 4'b0011 << addr_lo;
                wdata   = {2{store_data[15:0]}};
            end
            F3_W:    aligned = (addr_lo == 2'b00);
            // Undefined encodings are handled as word accesses.
            default: aligned = (addr_lo == 2'b00);
        endcase
    end

    always_comb begin
        load_data = lane;
        case (funct3)
            F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
            F3_BU:   load_data = {24'h0, lane[7:0]};
            F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
            F3_HU:   load_data = {16'h0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one req/gnt/rvalid data-memory access per load/store,
// stalls the pipeline until it completes, and holds extended load data for WB.
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipeline_en,
    input  logic        mem_load,
    input  logic        mem_store,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_store_data,
    output logic        lsu_stall,
    output logic [31:0] mem_read_data,
    output logic        misaligned,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]   rdata_q, rdata_d;

    logic        acc, aligned, mis, timed_out, complete;
    logic [31:0] load_ext;

    lsu_align u_align (
        .funct3     (mem_funct3),
        .addr_lo    (mem_addr[1:0]),
        .store_data (mem_store_data),
        .rdata      (dmem_rdata),
        .aligned    (aligned),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .load_data  (load_ext)
    );

    assign acc       = mem_load | mem_store;
    assign mis       = acc & ~aligned;
    assign cnt_inc   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign timed_out = (cnt_q >= CW'(TIMEOUT_CYCLES - 1));

    assign dmem_addr     = {mem_addr[31:2], 2'b00};
    assign dmem_we       = dmem_req & mem_store & ~mem_load;
    assign mem_read_data = rdata_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        rdata_d    = rdata_q;
        dmem_req   = 1'b0;
        lsu_stall  = 1'b0;
        misaligned = 1'b0;
        bus_err    = 1'b0;
        complete   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mis) begin
                    misaligned = 1'b1;
                end else if (acc) begin
                    dmem_req  = 1'b1;
                    lsu_stall = 1'b1;
                    if (!dmem_gnt)     state_d  = REQ;
                    else if (mem_load) state_d  = RESP;
                    else               complete = 1'b1;
                end
            end
            REQ: begin
                dmem_req  = 1'b1;
                lsu_stall = 1'b1;
                cnt_d     = cnt_inc;
                if (dmem_gnt) begin
                    if (mem_load) state_d  = RESP;
                    else          complete = 1'b1;
                end else if (timed_out) begin
                    bus_err  = 1'b1;
                    rdata_d  = '0;
                    complete = 1'b1;
                end
            end
            RESP: begin
                lsu_stall = 1'b1;
                cnt_d     = cnt_inc;
                if (dmem_rvalid) begin
                    rdata_d  = load_ext;
                    complete = 1'b1;
                end else if (timed_out) begin
                    bus_err  = 1'b1;
                    rdata_d  = '0;
                    complete = 1'b1;
                end
            end
            DONE: begin
                if (pipeline_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A finished access parks in DONE while the pipeline is held so it is not re-issued.
        if (complete) begin
            lsu_stall = 1'b0;
            state_d   = pipeline_en ? IDLE : DONE;
        end
        if (state_d == IDLE || state_d == DONE) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu; expected load results flow through a scoreboard queue.
// Inputs change on the falling edge, outputs are sampled 1ns later.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst, pipeline_en, mem_load, mem_store;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_store_data;
    logic        lsu_stall, misaligned, bus_err;
    logic [31:0] mem_read_data;
    logic        dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_rd;

    mem_stage_lsu #(.TIMEOUT_CYCLES(255)) dut (
        .clk            (clk),
        .rst            (rst),
        .pipeline_en    (pipeline_en),
        .mem_load       (mem_load),
        .mem_store      (mem_store),
        .mem_funct3     (mem_funct3),
        .mem_addr       (mem_addr),
        .mem_store_data (mem_store_data),
        .lsu_stall      (lsu_stall),
        .mem_read_data  (mem_read_data),
        .misaligned     (misaligned),
        .bus_err        (bus_err),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_be        (dmem_be),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_gnt       (dmem_gnt),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_load    = 1'b0;
        mem_store   = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    // Load granted in IDLE with rvalid on the following cycle.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        exp_q.push_back(exp);
        mem_load = 1'b1; mem_funct3 = f3; mem_addr = addr; dmem_gnt = 1'b1;
        #1;
        check("load_req",       {31'b0, dmem_req},  32'd1);
        check("load_we",        {31'b0, dmem_we},   32'd0);
        check("load_stall_c0",  {31'b0, lsu_stall}, 32'd1);
        check("load_addr",      dmem_addr, {addr[31:2], 2'b00});
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
        #1;
        check("load_stall_c1",  {31'b0, lsu_stall}, 32'd0);
        check("load_req_resp",  {31'b0, dmem_req},  32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        model_rd = exp_q.pop_front();
        check("load_data", mem_read_data, model_rd);
        $display("load f3=%b addr=%h rdata=%h -> %h", f3, addr, rdata, mem_read_data);
        @(negedge clk);
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        mem_store = 1'b1; mem_funct3 = f3; mem_addr = addr; mem_store_data = data; dmem_gnt = 1'b1;
        #1;
        check("store_req",   {31'b0, dmem_req},  32'd1);
        check("store_we",    {31'b0, dmem_we},   32'd1);
        check("store_be",    {28'b0, dmem_be},   {28'b0, exp_be});
        check("store_wdata", dmem_wdata, exp_wdata);
        check("store_addr",  dmem_addr, {addr[31:2], 2'b00});
        check("store_stall", {31'b0, lsu_stall}, 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("store_idle_req", {31'b0, dmem_req}, 32'd0);
        check("store_rd_hold",  mem_read_data, model_rd);
        $display("store f3=%b addr=%h data=%h be=%b", f3, addr, data, exp_be);
        @(negedge clk);
    endtask

    task automatic do_misaligned(input logic is_load, input logic [2:0] f3, input logic [31:0] addr);
        mem_load = is_load; mem_store = ~is_load; mem_funct3 = f3; mem_addr = addr; dmem_gnt = 1'b1;
        #1;
        check("mis_pulse", {31'b0, misaligned}, 32'd1);
        check("mis_req",   {31'b0, dmem_req},   32'd0);
        check("mis_stall", {31'b0, lsu_stall},  32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("mis_clear",  {31'b0, misaligned}, 32'd0);
        check("mis_rd_hold", mem_read_data, model_rd);
        $display("misaligned f3=%b addr=%h", f3, addr);
        @(negedge clk);
    endtask

    initial begin
        int early_err;
        int req_drop;
        rst = 1'b1; pipeline_en = 1'b1; mem_funct3 = 3'b010; mem_addr = '0;
        mem_store_data = '0; dmem_rdata = '0; model_rd = '0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_stall", {31'b0, lsu_stall},  32'd0);
        check("rst_req",   {31'b0, dmem_req},   32'd0);
        check("rst_mis",   {31'b0, misaligned}, 32'd0);
        check("rst_err",   {31'b0, bus_err},    32'd0);
        check("rst_rd",    mem_read_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_load(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load(3'b000, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80);
        do_load(3'b100, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0080);
        do_load(3'b001, 32'h0000_0102, 32'h8001_7FFF, 32'hFFFF_8001);
        do_store(3'b001, 32'h0000_0102, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
        do_store(3'b000, 32'h0000_0101, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
        do_store(3'b010, 32'h0000_0104, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        do_misaligned(1'b1, 3'b010, 32'h0000_0101);
        do_misaligned(1'b0, 3'b001, 32'h0000_0103);

        // Timeout: gnt never arrives; IDLE cycle then 255 REQ cycles.
        exp_q.push_back(32'h0);
        mem_load = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h0000_0200; dmem_gnt = 1'b0;
        early_err = 0; req_drop = 0;
        for (int i = 0; i < 255; i++) begin
            #1;
            if (bus_err !== 1'b0) early_err++;
            if (dmem_req !== 1'b1 || lsu_stall !== 1'b1) req_drop++;
            @(negedge clk);
        end
        #1;
        check("tmo_early_err", early_err, 0);
        check("tmo_req_held",  req_drop, 0);
        check("tmo_bus_err",   {31'b0, bus_err},   32'd1);
        check("tmo_stall",     {31'b0, lsu_stall}, 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        model_rd = exp_q.pop_front();
        check("tmo_rd_zero",  mem_read_data, model_rd);
        check("tmo_err_clr",  {31'b0, bus_err},  32'd0);
        check("tmo_idle_req", {31'b0, dmem_req}, 32'd0);
        $display("timeout addr=00000200 -> rd=%h", mem_read_data);
        @(negedge clk);

        // Completion while pipeline held: DONE, no re-issue, IDLE once released.
        exp_q.push_back(32'h0000_BEEF);
        mem_load = 1'b1; mem_funct3 = 3'b101; mem_addr = 32'h0000_0102; dmem_gnt = 1'b1;
        #1;
        check("hold_req_c0", {31'b0, dmem_req}, 32'd1);
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF_1234; pipeline_en = 1'b0;
        #1;
        check("hold_stall_c1", {31'b0, lsu_stall}, 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_gnt = 1'b1;
        #1;
        model_rd = exp_q.pop_front();
        check("hold_rd", mem_read_data, model_rd);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("hold_done_req",   {31'b0, dmem_req},  32'd0);
            check("hold_done_stall", {31'b0, lsu_stall}, 32'd0);
            @(negedge clk);
        end
        pipeline_en = 1'b1;
        #1;
        check("hold_release_req", {31'b0, dmem_req}, 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("hold_after_req", {31'b0, dmem_req}, 32'd0);
        check("hold_rd_keep",   mem_read_data, model_rd);
        $display("held load addr=00000102 -> %h", mem_read_data);
        @(negedge clk);

        // Reset while waiting in RESP; the late rvalid must be dropped.
        mem_load = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h0000_0300; dmem_gnt = 1'b1;
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        exp_q.push_back(32'h0);
        @(negedge clk);
        rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
        #1;
        check("rstmid_req",   {31'b0, dmem_req},  32'd0);
        check("rstmid_stall", {31'b0, lsu_stall}, 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        model_rd = exp_q.pop_front();
        check("rstmid_rd", mem_read_data, model_rd);
        $display("reset in RESP, late rvalid -> rd=%h", mem_read_data);
        @(negedge clk);

        do_load(3'b010, 32'h0000_0104, 32'h0123_4567, 32'h0123_4567);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
